// File: rtl/spc_sched_pkg.sv
// ----------------------------------------------------------------------------
// spc_sched_pkg
// Shared types and constants for the special-register write scheduler.
//   state_e      : scheduler FSM state (IDLE / LOCKED)
//   REQ_*        : requester indices (branch, stack, flags, user)
//   ZR .. CPSR   : special register file indices
//   lowest_idx() : index of the lowest set bit of a 4-bit vector
// ----------------------------------------------------------------------------
package spc_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [1:0] REQ_BR  = 2'd0;
  localparam logic [1:0] REQ_STK = 2'd1;
  localparam logic [1:0] REQ_FLG = 2'd2;
  localparam logic [1:0] REQ_USR = 2'd3;

  localparam logic [2:0] ZR   = 3'd0;
  localparam logic [2:0] R1   = 3'd1;
  localparam logic [2:0] R2   = 3'd2;
  localparam logic [2:0] R3   = 3'd3;
  localparam logic [2:0] SP   = 3'd4;
  localparam logic [2:0] LR   = 3'd5;
  localparam logic [2:0] PC   = 3'd6;
  localparam logic [2:0] CPSR = 3'd7;

  // Fixed-priority pick: lowest set index wins. Returns 0 for an empty vector;
  // callers qualify the result with a separate "any set" test.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spc_write_sched_if.sv
// ----------------------------------------------------------------------------
// spc_write_sched_if
// Bundle between the four write requesters and the scheduler, plus the
// scheduler's register-file write port and status.
//
// Handshake: a requester raises req[i] with addr/data (and lock[i]) and holds
// them stable until it sees gnt[i]. gnt[i] high at a rising clk edge means the
// request is consumed at that edge; a new request may be presented in the
// following cycle. There is no backpressure on the write side: wr_valid is a
// one-cycle strobe the register file must accept.
//
//   req[3:0]      requester -> sched   write request (0=br,1=stk,2=flg,3=usr)
//   lock[3:0]     requester -> sched   keep ownership after this grant
//   addr[11:0]    requester -> sched   3-bit target per requester, packed
//   data[127:0]   requester -> sched   32-bit data per requester, packed
//   gnt[3:0]      sched -> requester   one-hot combinational grant
//   wr_valid      sched -> regfile     registered write strobe
//   wr_addr[2:0]  sched -> regfile     registered write address
//   wr_data[31:0] sched -> regfile     registered write data
//   wr_src[1:0]   sched -> observers   requester behind current write
//   busy          sched -> observers   high while LOCKED
//   zr_drop       sched -> observers   pulse: write to ZR discarded
//   dbg_state     sched -> observers   FSM state
// ----------------------------------------------------------------------------
interface spc_write_sched_if;
  import spc_sched_pkg::*;

  logic [3:0]   req;
  logic [3:0]   lock;
  logic [11:0]  addr;
  logic [127:0] data;
  logic [3:0]   gnt;
  logic         wr_valid;
  logic [2:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [1:0]   wr_src;
  logic         busy;
  logic         zr_drop;
  state_e       dbg_state;

  modport master (
    output req, lock, addr, data,
    input  gnt, wr_valid, wr_addr, wr_data, wr_src, busy, zr_drop, dbg_state
  );

  modport slave (
    input  req, lock, addr, data,
    output gnt, wr_valid, wr_addr, wr_data, wr_src, busy, zr_drop, dbg_state
  );

endinterface

// File: rtl/spc_age_ctr.sv
// ----------------------------------------------------------------------------
// spc_age_ctr
// Saturating wait counter for one requester. Used only when the design is
// built with SPC_SCHED_AGING_EN defined.
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   req_i     in   requester's req
//   gnt_i     in   requester's gnt
//   count_o   out  cycles waited (saturates at WAIT_MAX)
//   at_max_o  out  count_o == WAIT_MAX
// ----------------------------------------------------------------------------
module spc_age_ctr #(
  parameter int WAIT_MAX = 7,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_i,
  input  logic          gnt_i,
  output logic [CW-1:0] count_o,
  output logic          at_max_o
);

  localparam logic [CW-1:0] MAX_C = CW'(WAIT_MAX);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!req_i || gnt_i) begin
      count_d = '0;
    end else if (count_q != MAX_C) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == MAX_C);

endmodule

// File: rtl/spc_write_sched.sv
// ----------------------------------------------------------------------------
// spc_write_sched
// Write-port scheduler for the special register file. Grants at most one of
// four requesters per cycle (fixed priority, lowest index first), supports
// short locked multi-write sequences, and issues one registered write.
// Writes to ZR are acknowledged but dropped, with a zr_drop pulse.
//
// Optional feature macro: SPC_SCHED_AGING_EN
//   defined   : per-requester age counters; a requester that waited WAIT_MAX
//               cycles beats fixed priority in IDLE.
//   undefined : pure fixed priority, no counters, WAIT_MAX unused.
//
// Parameters: WAIT_MAX (aging threshold), LOCK_MAX (max cycles per lock).
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    spc_write_sched_if.slave (requests, grant, write port, status)
// ----------------------------------------------------------------------------
module spc_write_sched
  import spc_sched_pkg::*;
#(
  parameter int WAIT_MAX = 7,
  parameter int LOCK_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  spc_write_sched_if.slave   bus
);

  // One spare bit so the increment past LOCK_MAX can never wrap.
  localparam int              LW         = $clog2(LOCK_MAX + 2);
  localparam logic [LW-1:0]   LOCK_MAX_C = LW'(LOCK_MAX);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [LW-1:0] lcnt_q, lcnt_d;

  logic [3:0]    gnt_c;
  logic [3:0]    promoted;
  logic [1:0]    win;

  logic          wr_valid_q, wr_valid_d;
  logic [2:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [1:0]    wr_src_q, wr_src_d;
  logic          zr_drop_q, zr_drop_d;

  // --------------------------------------------------------------------------
  // Starvation aging
  // --------------------------------------------------------------------------
`ifdef SPC_SCHED_AGING_EN
  localparam int AGE_W = $clog2(WAIT_MAX + 1);

  logic [3:0]       at_max;
  logic [AGE_W-1:0] age_cnt_unused [4];

  for (genvar g = 0; g < 4; g++) begin : g_age
    spc_age_ctr #(
      .WAIT_MAX (WAIT_MAX),
      .CW       (AGE_W)
    ) u_age (
      .clk      (clk),
      .reset    (reset),
      .req_i    (bus.req[g]),
      .gnt_i    (gnt_c[g]),
      .count_o  (age_cnt_unused[g]),
      .at_max_o (at_max[g])
    );
  end

  assign promoted = bus.req & at_max;
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX != 0);
  assign promoted        = '0;
`endif

  // --------------------------------------------------------------------------
  // FSM: next state and grant
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lcnt_d  = lcnt_q;
    gnt_c   = '0;
    win     = (promoted != '0) ? lowest_idx(promoted) : lowest_idx(bus.req);

    unique case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          gnt_c[win] = 1'b1;
          if (bus.lock[win]) begin
            state_d = LOCKED;
            owner_d = win;
            lcnt_d  = LW'(1);
          end
        end
      end
      LOCKED: begin
        lcnt_d = lcnt_q + LW'(1);
        if (bus.req[owner_q]) gnt_c[owner_q] = 1'b1;
        // Release takes effect at the edge; nobody else is granted this
        // cycle, so new arbitration starts in the following cycle.
        if (!bus.req[owner_q] || !bus.lock[owner_q] || (lcnt_d >= LOCK_MAX_C)) begin
          state_d = IDLE;
          lcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // gnt is combinational from req; hold it low while reset is asserted.
    if (!reset) gnt_c = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write issue
  // --------------------------------------------------------------------------
  always_comb begin
    wr_valid_d = 1'b0;
    zr_drop_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_src_d   = wr_src_q;
    for (int i = 0; i < 4; i++) begin
      if (gnt_c[i]) begin
        wr_addr_d = bus.addr[3*i +: 3];
        wr_data_d = bus.data[32*i +: 32];
        wr_src_d  = 2'(i);
        // ZR is hard-wired zero: acknowledge but never strobe the regfile.
        if (bus.addr[3*i +: 3] == ZR) zr_drop_d  = 1'b1;
        else                          wr_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_src_q   <= '0;
      zr_drop_q  <= 1'b0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_src_q   <= wr_src_d;
      zr_drop_q  <= zr_drop_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_src    = wr_src_q;
  assign bus.zr_drop   = zr_drop_q;
  assign bus.busy      = (state_q == LOCKED);
  assign bus.dbg_state = state_q;

endmodule
